// File: rtl/rtm_port_arb_if.sv
// Request, return and memory-port bundle for the RTM port arbiter.
// The arbiter takes the slave view; requesters and the RTM bank take the master view.
interface rtm_port_arb_if #(
    parameter int unsigned S     = 4,
    parameter int unsigned R     = 2,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = S * R * 8;

    // write requesters
    logic          ld_wr_valid;
    logic          ld_wr_ready;
    logic          ld_wr_last;
    logic [S-1:0]  ld_wr_mask;
    logic [AW-1:0] ld_wr_addr;
    logic [DW-1:0] ld_wr_data;

    logic          ex_wr_valid;
    logic          ex_wr_ready;
    logic          ex_wr_last;
    logic [S-1:0]  ex_wr_mask;
    logic [AW-1:0] ex_wr_addr;
    logic [DW-1:0] ex_wr_data;

    // read requesters and their returns
    logic          ex_rd_valid;
    logic          ex_rd_ready;
    logic          ex_rd_last;
    logic [S-1:0]  ex_rd_mask;
    logic [AW-1:0] ex_rd_addr;
    logic          ex_rd_dout_vld;
    logic [DW-1:0] ex_rd_dout;

    logic          st_rd_valid;
    logic          st_rd_ready;
    logic          st_rd_last;
    logic [S-1:0]  st_rd_mask;
    logic [AW-1:0] st_rd_addr;
    logic          st_rd_dout_vld;
    logic [DW-1:0] st_rd_dout;

    // RTM bank ports
    logic [S-1:0]    mem_wr_en;
    logic [S*AW-1:0] mem_wr_addr;
    logic [DW-1:0]   mem_din;
    logic [S-1:0]    mem_rd_en;
    logic [S*AW-1:0] mem_rd_addr;
    logic [DW-1:0]   mem_dout;

    modport slave (
        input  ld_wr_valid, ld_wr_last, ld_wr_mask, ld_wr_addr, ld_wr_data,
        input  ex_wr_valid, ex_wr_last, ex_wr_mask, ex_wr_addr, ex_wr_data,
        input  ex_rd_valid, ex_rd_last, ex_rd_mask, ex_rd_addr,
        input  st_rd_valid, st_rd_last, st_rd_mask, st_rd_addr,
        input  mem_dout,
        output ld_wr_ready, ex_wr_ready, ex_rd_ready, st_rd_ready,
        output ex_rd_dout_vld, ex_rd_dout, st_rd_dout_vld, st_rd_dout,
        output mem_wr_en, mem_wr_addr, mem_din, mem_rd_en, mem_rd_addr
    );

    modport master (
        output ld_wr_valid, ld_wr_last, ld_wr_mask, ld_wr_addr, ld_wr_data,
        output ex_wr_valid, ex_wr_last, ex_wr_mask, ex_wr_addr, ex_wr_data,
        output ex_rd_valid, ex_rd_last, ex_rd_mask, ex_rd_addr,
        output st_rd_valid, st_rd_last, st_rd_mask, st_rd_addr,
        output mem_dout,
        input  ld_wr_ready, ex_wr_ready, ex_rd_ready, st_rd_ready,
        input  ex_rd_dout_vld, ex_rd_dout, st_rd_dout_vld, st_rd_dout,
        input  mem_wr_en, mem_wr_addr, mem_din, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/rtm_port_arb.sv
// RTM bank port arbiter: round-robin/burst-locking arbitration of the shared write
// and read ports, registered memory issue, and tag-steered read return.

// Two-requester arbiter with burst ownership; ready is combinational to the grantee.
module rtm_port_arb_fsm (
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic a_last,
    input  logic b_valid,
    input  logic b_last,
    output logic a_ready,
    output logic b_ready,
    output logic a_fire,
    output logic b_fire
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_b;
    logic   last_b_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_b <= 1'b1;
        end else begin
            state  <= state_nxt;
            last_b <= last_b_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_b_nxt = last_b;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        a_fire     = 1'b0;
        b_fire     = 1'b0;

        if (!rst) begin
            unique case (state)
                IDLE: begin
                    // contention goes to whoever was not granted last
                    if (a_valid && (!b_valid || last_b)) begin
                        a_ready = 1'b1;
                    end else if (b_valid) begin
                        b_ready = 1'b1;
                    end
                end
                OWN_A:   a_ready = 1'b1;
                OWN_B:   b_ready = 1'b1;
                default: state_nxt = IDLE;
            endcase
        end

        a_fire = a_ready && a_valid;
        b_fire = b_ready && b_valid;

        if (a_fire) begin
            last_b_nxt = 1'b0;
            state_nxt  = a_last ? IDLE : OWN_A;
        end else if (b_fire) begin
            last_b_nxt = 1'b1;
            state_nxt  = b_last ? IDLE : OWN_B;
        end
    end
endmodule

module rtm_port_arb #(
    parameter int unsigned S      = 4,
    parameter int unsigned R      = 2,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned RD_LAT = 3
) (
    input logic             clk,
    input logic             rst,
    rtm_port_arb_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = R * 8;
    localparam int unsigned DW = S * SW;

    typedef struct packed {
        logic         vld;
        logic         id;    // 0: ex, 1: st
        logic [S-1:0] mask;
    } tag_t;

    logic ld_wr_rdy;
    logic ex_wr_rdy;
    logic ex_rd_rdy;
    logic st_rd_rdy;
    logic ld_wr_hs;
    logic ex_wr_hs;
    logic ex_rd_hs;
    logic st_rd_hs;

    rtm_port_arb_fsm u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (bus.ld_wr_valid),
        .a_last  (bus.ld_wr_last),
        .b_valid (bus.ex_wr_valid),
        .b_last  (bus.ex_wr_last),
        .a_ready (ld_wr_rdy),
        .b_ready (ex_wr_rdy),
        .a_fire  (ld_wr_hs),
        .b_fire  (ex_wr_hs)
    );

    rtm_port_arb_fsm u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (bus.ex_rd_valid),
        .a_last  (bus.ex_rd_last),
        .b_valid (bus.st_rd_valid),
        .b_last  (bus.st_rd_last),
        .a_ready (ex_rd_rdy),
        .b_ready (st_rd_rdy),
        .a_fire  (ex_rd_hs),
        .b_fire  (st_rd_hs)
    );

    assign bus.ld_wr_ready = ld_wr_rdy;
    assign bus.ex_wr_ready = ex_wr_rdy;
    assign bus.ex_rd_ready = ex_rd_rdy;
    assign bus.st_rd_ready = st_rd_rdy;

    // write issue: accepted beat lands on the memory port one cycle later
    logic [S-1:0]  wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= '0;
            if (ld_wr_hs) begin
                wr_en_q   <= bus.ld_wr_mask;
                wr_addr_q <= bus.ld_wr_addr;
                wr_data_q <= bus.ld_wr_data;
            end else if (ex_wr_hs) begin
                wr_en_q   <= bus.ex_wr_mask;
                wr_addr_q <= bus.ex_wr_addr;
                wr_data_q <= bus.ex_wr_data;
            end
        end
    end

    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = {S{wr_addr_q}};
    assign bus.mem_din     = wr_data_q;

    // read issue plus tag; stage 0 rides with mem_rd_en, stage RD_LAT lines up with mem_dout
    logic [S-1:0]  rd_en_q;
    logic [AW-1:0] rd_addr_q;
    tag_t          tag_in;
    tag_t          tag_pipe [RD_LAT+1];

    always_comb begin
        tag_in = '0;
        if (ex_rd_hs) begin
            tag_in.vld  = 1'b1;
            tag_in.id   = 1'b0;
            tag_in.mask = bus.ex_rd_mask;
        end else if (st_rd_hs) begin
            tag_in.vld  = 1'b1;
            tag_in.id   = 1'b1;
            tag_in.mask = bus.st_rd_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q   <= '0;
            rd_addr_q <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            rd_en_q <= '0;
            if (ex_rd_hs) begin
                rd_en_q   <= bus.ex_rd_mask;
                rd_addr_q <= bus.ex_rd_addr;
            end else if (st_rd_hs) begin
                rd_en_q   <= bus.st_rd_mask;
                rd_addr_q <= bus.st_rd_addr;
            end
            tag_pipe[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = {S{rd_addr_q}};

    // read return: steer by tag id, zero the slices that were not enabled
    tag_t          ret;
    logic          ex_ret;
    logic          st_ret;
    logic [DW-1:0] ret_data;

    assign ret    = tag_pipe[RD_LAT];
    assign ex_ret = ret.vld && !ret.id && !rst;
    assign st_ret = ret.vld && ret.id && !rst;

    always_comb begin
        ret_data = '0;
        for (int s = 0; s < S; s++) begin
            ret_data[s*SW +: SW] = ret.mask[s] ? bus.mem_dout[s*SW +: SW] : '0;
        end
    end

    assign bus.ex_rd_dout_vld = ex_ret;
    assign bus.ex_rd_dout     = ex_ret ? ret_data : '0;
    assign bus.st_rd_dout_vld = st_ret;
    assign bus.st_rd_dout     = st_ret ? ret_data : '0;
endmodule

// File: tb/tb_rtm_port_arb.sv
// Bench for rtm_port_arb: URAM stand-in, spec-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_rtm_port_arb;
    localparam int unsigned S      = 4;
    localparam int unsigned R      = 2;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned SW     = R * 8;
    localparam int unsigned DW     = S * SW;
    localparam int unsigned RING   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rtm_port_arb_if #(.S(S), .R(R), .DEPTH(DEPTH)) bus ();

    rtm_port_arb #(.S(S), .R(R), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] pre(input int s, input int a);
        if (a == 5) return 16'hA5A5;
        return {8'(a), 8'(s)};
    endfunction

    function automatic logic [DW-1:0] row_pre(input int a);
        logic [DW-1:0] r;
        for (int s = 0; s < S; s++) r[s*SW +: SW] = pre(s, a);
        return r;
    endfunction

    function automatic logic [S*AW-1:0] rep(input logic [AW-1:0] a);
        logic [S*AW-1:0] r;
        for (int s = 0; s < S; s++) r[s*AW +: AW] = a;
        return r;
    endfunction

    function automatic logic [DW-1:0] msk(input logic [DW-1:0] d, input logic [S-1:0] m);
        logic [DW-1:0] r;
        for (int s = 0; s < S; s++) r[s*SW +: SW] = m[s] ? d[s*SW +: SW] : '0;
        return r;
    endfunction

    // URAM stand-in: read captured at the edge, visible RD_LAT cycles after mem_rd_en
    logic [SW-1:0] mem  [S][DEPTH];
    logic [DW-1:0] pipe [RD_LAT];
    bit            loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int s = 0; s < S; s++)
                for (int a = 0; a < DEPTH; a++) mem[s][a] <= pre(s, a);
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
            loaded <= 1'b1;
        end else begin
            for (int s = 0; s < S; s++)
                if (bus.mem_rd_en[s]) pipe[0][s*SW +: SW] <= mem[s][bus.mem_rd_addr[s*AW +: AW]];
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            for (int s = 0; s < S; s++)
                if (bus.mem_wr_en[s]) mem[s][bus.mem_wr_addr[s*AW +: AW]] <= bus.mem_din[s*SW +: SW];
        end
    end
    assign bus.mem_dout = pipe[RD_LAT-1];

    // reference model state: owner 0=none 1=A 2=B, plus who won last
    int            wr_own, rd_own;
    bit            wr_last_b, rd_last_b;
    logic [DW-1:0] shadow [DEPTH];
    bit   [S-1:0]  e_wr_en [RING];
    logic [AW-1:0] e_wr_addr [RING];
    logic [DW-1:0] e_wr_din [RING];
    bit            e_wr_chk [RING];
    bit   [S-1:0]  e_rd_en [RING];
    logic [AW-1:0] e_rd_addr [RING];
    bit            e_rd_chk [RING];
    bit            e_ex_vld [RING];
    bit            e_st_vld [RING];
    logic [DW-1:0] e_ex_dout [RING];
    logic [DW-1:0] e_st_dout [RING];

    task automatic clr(input int i);
        e_wr_en[i] = '0; e_wr_addr[i] = '0; e_wr_din[i] = '0; e_wr_chk[i] = 1'b0;
        e_rd_en[i] = '0; e_rd_addr[i] = '0; e_rd_chk[i] = 1'b0;
        e_ex_vld[i] = 1'b0; e_st_vld[i] = 1'b0; e_ex_dout[i] = '0; e_st_dout[i] = '0;
    endtask

    function automatic void arb(input bit r, input int own, input bit last_b,
                                input bit av, input bit bv, output bit ar, output bit br);
        ar = 1'b0;
        br = 1'b0;
        if (r) return;
        if (own == 1) ar = 1'b1;
        else if (own == 2) br = 1'b1;
        else if (av && (!bv || last_b)) ar = 1'b1;
        else if (bv) br = 1'b1;
    endfunction

    task automatic upd(inout int own, inout bit last_b, input bit ha, input bit hb,
                       input bit al, input bit bl);
        if (ha) begin
            last_b = 1'b0;
            own    = al ? 0 : 1;
        end else if (hb) begin
            last_b = 1'b1;
            own    = bl ? 0 : 2;
        end
    endtask

    // per-cycle compare against the model, sampled mid-cycle
    initial begin
        bit ldr, exwr, exrr, strr, hld, hexw, hexr, hstr;
        int k, kn, kr;
        for (int a = 0; a < DEPTH; a++) shadow[a] = row_pre(a);
        for (int i = 0; i < RING; i++) clr(i);
        wr_own = 0; rd_own = 0; wr_last_b = 1'b1; rd_last_b = 1'b1;
        forever begin
            @(negedge clk);
            k  = cyc % RING;
            kn = (cyc + 1) % RING;
            kr = (cyc + 1 + RD_LAT) % RING;
            arb(rst, wr_own, wr_last_b, bus.ld_wr_valid, bus.ex_wr_valid, ldr, exwr);
            arb(rst, rd_own, rd_last_b, bus.ex_rd_valid, bus.st_rd_valid, exrr, strr);
            chk("ld_wr_ready", 64'(bus.ld_wr_ready), 64'(ldr));
            chk("ex_wr_ready", 64'(bus.ex_wr_ready), 64'(exwr));
            chk("ex_rd_ready", 64'(bus.ex_rd_ready), 64'(exrr));
            chk("st_rd_ready", 64'(bus.st_rd_ready), 64'(strr));
            if (rst) begin
                e_ex_vld[k] = 1'b0; e_st_vld[k] = 1'b0; e_ex_dout[k] = '0; e_st_dout[k] = '0;
            end
            chk("mem_wr_en", 64'(bus.mem_wr_en), 64'(e_wr_en[k]));
            if (e_wr_chk[k]) begin
                chk("mem_wr_addr", 64'(bus.mem_wr_addr), 64'(rep(e_wr_addr[k])));
                chk("mem_din", 64'(bus.mem_din), 64'(e_wr_din[k]));
            end
            chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(e_rd_en[k]));
            if (e_rd_chk[k]) chk("mem_rd_addr", 64'(bus.mem_rd_addr), 64'(rep(e_rd_addr[k])));
            chk("ex_rd_dout_vld", 64'(bus.ex_rd_dout_vld), 64'(e_ex_vld[k]));
            chk("ex_rd_dout", 64'(bus.ex_rd_dout), 64'(e_ex_dout[k]));
            chk("st_rd_dout_vld", 64'(bus.st_rd_dout_vld), 64'(e_st_vld[k]));
            chk("st_rd_dout", 64'(bus.st_rd_dout), 64'(e_st_dout[k]));
            clr(k);
            if (rst) begin
                for (int i = 0; i < RING; i++) clr(i);
                wr_own = 0; rd_own = 0; wr_last_b = 1'b1; rd_last_b = 1'b1;
            end else begin
                hld  = ldr  && bus.ld_wr_valid;
                hexw = exwr && bus.ex_wr_valid;
                hexr = exrr && bus.ex_rd_valid;
                hstr = strr && bus.st_rd_valid;
                // reads see memory before this cycle's write
                if (hexr) begin
                    e_rd_en[kn] = bus.ex_rd_mask; e_rd_addr[kn] = bus.ex_rd_addr; e_rd_chk[kn] = 1'b1;
                    e_ex_vld[kr] = 1'b1; e_ex_dout[kr] = msk(shadow[bus.ex_rd_addr], bus.ex_rd_mask);
                end else if (hstr) begin
                    e_rd_en[kn] = bus.st_rd_mask; e_rd_addr[kn] = bus.st_rd_addr; e_rd_chk[kn] = 1'b1;
                    e_st_vld[kr] = 1'b1; e_st_dout[kr] = msk(shadow[bus.st_rd_addr], bus.st_rd_mask);
                end
                if (hld || hexw) begin
                    logic [S-1:0]  m;
                    logic [AW-1:0] a;
                    logic [DW-1:0] d;
                    m = hld ? bus.ld_wr_mask : bus.ex_wr_mask;
                    a = hld ? bus.ld_wr_addr : bus.ex_wr_addr;
                    d = hld ? bus.ld_wr_data : bus.ex_wr_data;
                    e_wr_en[kn] = m; e_wr_addr[kn] = a; e_wr_din[kn] = d; e_wr_chk[kn] = 1'b1;
                    for (int s = 0; s < S; s++)
                        if (m[s]) shadow[a][s*SW +: SW] = d[s*SW +: SW];
                end
                upd(wr_own, wr_last_b, hld, hexw, bus.ld_wr_last, bus.ex_wr_last);
                upd(rd_own, rd_last_b, hexr, hstr, bus.ex_rd_last, bus.st_rd_last);
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.ld_wr_valid = 0; bus.ld_wr_last = 0; bus.ld_wr_mask = '0; bus.ld_wr_addr = '0; bus.ld_wr_data = '0;
        bus.ex_wr_valid = 0; bus.ex_wr_last = 0; bus.ex_wr_mask = '0; bus.ex_wr_addr = '0; bus.ex_wr_data = '0;
        bus.ex_rd_valid = 0; bus.ex_rd_last = 0; bus.ex_rd_mask = '0; bus.ex_rd_addr = '0;
        bus.st_rd_valid = 0; bus.st_rd_last = 0; bus.st_rd_mask = '0; bus.st_rd_addr = '0;
    endtask

    task automatic ex_rd(input logic [AW-1:0] a, input logic [S-1:0] m);
        bus.ex_rd_valid = 1; bus.ex_rd_last = 1; bus.ex_rd_addr = a; bus.ex_rd_mask = m;
    endtask

    initial begin
        bit ld_v [7];
        bit ld_l [7];
        idle_all();
        // reset: requests are refused
        bus.ld_wr_valid = 1;
        repeat (3) step();
        #2;
        chk("rst_ld_ready", 64'(bus.ld_wr_ready), 64'd0);
        chk("rst_mem_wr_en", 64'(bus.mem_wr_en), 64'd0);
        step();
        idle_all();
        rst = 1'b0;

        // single read of row 5
        step();
        ex_rd(4'd5, 4'hF);
        #2 chk("t1_ready", 64'(bus.ex_rd_ready), 64'd1);
        step();
        idle_all();
        #2;
        chk("t1_rd_en", 64'(bus.mem_rd_en), 64'hF);
        chk("t1_rd_addr", 64'(bus.mem_rd_addr), 64'h5555);
        for (int d = 2; d <= 4; d++) begin
            step();
            #2;
            chk("t1_vld", 64'(bus.ex_rd_dout_vld), (d == 4) ? 64'd1 : 64'd0);
            chk("t1_st_vld", 64'(bus.st_rd_dout_vld), 64'd0);
        end
        chk("t1_dout", 64'(bus.ex_rd_dout), 64'hA5A5_A5A5_A5A5_A5A5);

        // interleaved ex@1 (slice 0 only), st@2, ex@3
        step(); ex_rd(4'd1, 4'b0001);
        step(); idle_all(); bus.st_rd_valid = 1; bus.st_rd_last = 1; bus.st_rd_addr = 4'd2; bus.st_rd_mask = 4'hF;
        step(); idle_all(); ex_rd(4'd3, 4'b0001);
        step(); idle_all();
        step(); #2;
        chk("t4_ex1", 64'(bus.ex_rd_dout), 64'h0000_0000_0000_0100);
        step(); #2;
        chk("t4_st2_vld", 64'(bus.st_rd_dout_vld), 64'd1);
        chk("t4_st2", 64'(bus.st_rd_dout), 64'h0203_0202_0201_0200);
        step(); #2;
        chk("t4_ex3", 64'(bus.ex_rd_dout), 64'h0000_0000_0000_0300);

        // same-cycle read and write of row 7
        step();
        ex_rd(4'd7, 4'hF);
        bus.ld_wr_valid = 1; bus.ld_wr_last = 1; bus.ld_wr_addr = 4'd7; bus.ld_wr_mask = 4'hF; bus.ld_wr_data = '1;
        step(); idle_all();
        repeat (3) step();
        #2 chk("t5_old", 64'(bus.ex_rd_dout), 64'h0703_0702_0701_0700);
        step(); ex_rd(4'd7, 4'hF);
        step(); idle_all();
        repeat (3) step();
        #2 chk("t5_new", 64'(bus.ex_rd_dout), 64'hFFFF_FFFF_FFFF_FFFF);

        // round robin on the write port straight out of reset
        step(); rst = 1'b1;
        step(); step();
        rst = 1'b0;
        bus.ld_wr_valid = 1; bus.ld_wr_last = 1; bus.ld_wr_addr = 4'd1; bus.ld_wr_mask = 4'hF; bus.ld_wr_data = {4{16'h1111}};
        bus.ex_wr_valid = 1; bus.ex_wr_last = 1; bus.ex_wr_addr = 4'd2; bus.ex_wr_mask = 4'hF; bus.ex_wr_data = {4{16'h2222}};
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t2_ld_ready", 64'(bus.ld_wr_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("t2_ex_ready", 64'(bus.ex_wr_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            if (i > 0) chk("t2_wr_addr", 64'(bus.mem_wr_addr), (i % 2 == 1) ? 64'h1111 : 64'h2222);
            step();
        end
        idle_all();

        // ld burst of 4 with a 2-cycle gap while ex waits
        ld_v = '{1, 1, 0, 0, 1, 1, 0};
        ld_l = '{0, 0, 0, 0, 0, 1, 0};
        step();
        bus.ex_wr_valid = 1; bus.ex_wr_last = 1; bus.ex_wr_addr = 4'd3; bus.ex_wr_mask = 4'hF; bus.ex_wr_data = {4{16'h3333}};
        bus.ld_wr_addr = 4'd8; bus.ld_wr_mask = 4'hF; bus.ld_wr_data = {4{16'h8888}};
        for (int i = 0; i < 7; i++) begin
            bus.ld_wr_valid = ld_v[i];
            bus.ld_wr_last  = ld_l[i];
            #2 chk("t3_ex_ready", 64'(bus.ex_wr_ready), (i == 6) ? 64'd1 : 64'd0);
            step();
        end
        idle_all();

        // reset with two reads in flight and an open ld burst
        step(); ex_rd(4'd1, 4'hF);
        step(); idle_all();
        bus.st_rd_valid = 1; bus.st_rd_last = 1; bus.st_rd_addr = 4'd2; bus.st_rd_mask = 4'hF;
        bus.ld_wr_valid = 1; bus.ld_wr_last = 0; bus.ld_wr_addr = 4'd4; bus.ld_wr_mask = 4'hF; bus.ld_wr_data = '0;
        step(); idle_all(); rst = 1'b1;
        step(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("t6_ex_vld", 64'(bus.ex_rd_dout_vld), 64'd0);
            chk("t6_st_vld", 64'(bus.st_rd_dout_vld), 64'd0);
            step();
        end
        bus.ld_wr_valid = 1; bus.ld_wr_last = 1; bus.ex_wr_valid = 1; bus.ex_wr_last = 1;
        #2;
        chk("t6_ld_first", 64'(bus.ld_wr_ready), 64'd1);
        chk("t6_ex_wait", 64'(bus.ex_wr_ready), 64'd0);
        step(); idle_all();

        // randomized traffic, occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(299) == 0);
            bus.ld_wr_valid = ($urandom_range(9) < 7); bus.ld_wr_last = ($urandom_range(2) == 0);
            bus.ld_wr_mask = S'($urandom); bus.ld_wr_addr = AW'($urandom); bus.ld_wr_data = {$urandom, $urandom};
            bus.ex_wr_valid = ($urandom_range(9) < 7); bus.ex_wr_last = ($urandom_range(2) == 0);
            bus.ex_wr_mask = S'($urandom); bus.ex_wr_addr = AW'($urandom); bus.ex_wr_data = {$urandom, $urandom};
            bus.ex_rd_valid = ($urandom_range(9) < 7); bus.ex_rd_last = ($urandom_range(2) == 0);
            bus.ex_rd_mask = S'($urandom); bus.ex_rd_addr = AW'($urandom);
            bus.st_rd_valid = ($urandom_range(9) < 7); bus.st_rd_last = ($urandom_range(2) == 0);
            bus.st_rd_mask = S'($urandom); bus.st_rd_addr = AW'($urandom);
            step();
        end
        rst = 1'b0;
        idle_all();
        repeat (10) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
